// File: rtl/decode_issue.sv
// Decode/operand-issue stage feeding the Executer: assembles 16/32-bit V850 instructions,
// reads GR, inserts a single RAW bubble and drives registered operands every cycle.
module decode_issue #(
    parameter logic [9:0] NOP_SEL      = 10'h200,
    parameter bit         HAZARD_CHECK = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [15:0]       hw_i,
    input  logic              hw_valid_i,
    output logic              hw_ready_o,
    input  logic              flush_i,
    input  logic [31:0][31:0] gr_i,
    output logic [4:0]        destination_o,
    output logic [31:0]       reg1_o,
    output logic [31:0]       reg2_o,
    output logic [31:0]       reg3_o,
    output logic              increment_bit_o,
    output logic [9:0]        circuit_sel_o,
    output logic              illegal_o
);
    typedef enum logic [1:0] {S_FIRST, S_SECOND, S_STALL} state_t;

    localparam logic [5:0] OP_ADD   = 6'b001110;
    localparam logic [5:0] OP_ADDI5 = 6'b010010;
    localparam logic [5:0] OP_SUB   = 6'b001101;
    localparam logic [5:0] OP_CMP   = 6'b001111;
    localparam logic [5:0] OP_CMPI5 = 6'b010011;
    localparam logic [5:0] OP_AND   = 6'b001010;
    localparam logic [5:0] OP_OR    = 6'b001000;
    localparam logic [5:0] OP_DIVH  = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b110000;
    localparam logic [5:0] OP_ANDI  = 6'b110110;
    localparam logic [5:0] OP_ORI   = 6'b110100;

    state_t      r_state, w_state_next;
    logic [15:0] r_hw, r_imm;
    logic [4:0]  r_dest;
    logic [31:0] r_reg1, r_reg2;
    logic [9:0]  r_sel;
    logic        r_illegal, r_issued;

    logic [15:0] w_hw, w_imm;
    logic [4:0]  w_f_reg1, w_f_reg2;
    logic [5:0]  w_op;
    logic [31:0] w_gr1, w_gr2, w_sext5;
    logic        w_legal, w_long, w_use1, w_use2;
    logic [9:0]  w_sel;
    logic [4:0]  w_dest;
    logic [31:0] w_op1, w_op2;
    logic        w_accept, w_hazard, w_issue, w_latch_hw, w_latch_imm, w_illegal_next;

    // Outside FIRST the opcode halfword comes from the holding register.
    assign w_hw     = (r_state == S_FIRST) ? hw_i : r_hw;
    assign w_imm    = (r_state == S_SECOND) ? hw_i : r_imm;
    assign w_f_reg2 = w_hw[15:11];
    assign w_op     = w_hw[10:5];
    assign w_f_reg1 = w_hw[4:0];
    assign w_gr1    = (w_f_reg1 == 5'd0) ? 32'd0 : gr_i[w_f_reg1];
    assign w_gr2    = (w_f_reg2 == 5'd0) ? 32'd0 : gr_i[w_f_reg2];
    assign w_sext5  = {{27{w_f_reg1[4]}}, w_f_reg1};

    always_comb begin
        w_legal = 1'b1;
        w_long  = 1'b0;
        w_use1  = 1'b1;
        w_use2  = 1'b1;
        w_sel   = NOP_SEL;
        w_dest  = w_f_reg2;
        w_op1   = w_gr1;
        w_op2   = w_gr2;
        case (w_op)
            OP_ADD:   w_sel = 10'h020;
            OP_ADDI5: begin w_sel = 10'h020; w_op1 = w_sext5; w_use1 = 1'b0; end
            OP_SUB:   begin w_sel = 10'h000; w_op1 = -w_gr1; end
            OP_CMP:   begin w_sel = 10'h000; w_op1 = -w_gr1; w_dest = 5'd0; end
            OP_CMPI5: begin w_sel = 10'h000; w_op1 = -w_sext5; w_use1 = 1'b0; w_dest = 5'd0; end
            OP_AND:   w_sel = 10'h002;
            OP_OR:    w_sel = 10'h003;
            OP_DIVH:  begin w_sel = 10'h008; w_op1 = {{16{w_gr1[15]}}, w_gr1[15:0]}; end
            OP_ADDI:  begin
                w_long = 1'b1; w_sel = 10'h020; w_use2 = 1'b0;
                w_op1 = {{16{w_imm[15]}}, w_imm}; w_op2 = w_gr1;
            end
            OP_ANDI:  begin
                w_long = 1'b1; w_sel = 10'h002; w_use2 = 1'b0;
                w_op1 = {16'h0000, w_imm}; w_op2 = w_gr1;
            end
            OP_ORI:   begin
                w_long = 1'b1; w_sel = 10'h003; w_use2 = 1'b0;
                w_op1 = {16'h0000, w_imm}; w_op2 = w_gr1;
            end
            default:  begin w_legal = 1'b0; w_use1 = 1'b0; w_use2 = 1'b0; end
        endcase
    end

    assign hw_ready_o = (r_state != S_STALL) && !flush_i;
    assign w_accept   = hw_valid_i && hw_ready_o;
    // r_issued distinguishes a real issue from held outputs behind a NOP.
    assign w_hazard   = HAZARD_CHECK && r_issued && (r_dest != 5'd0) &&
                        ((w_use1 && (w_f_reg1 == r_dest)) || (w_use2 && (w_f_reg2 == r_dest)));

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_FIRST;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next   = r_state;
        w_issue        = 1'b0;
        w_latch_hw     = 1'b0;
        w_latch_imm    = 1'b0;
        w_illegal_next = 1'b0;
        if (flush_i) begin
            w_state_next = S_FIRST;
        end else begin
            case (r_state)
                S_FIRST: if (w_accept) begin
                    if (!w_legal)      w_illegal_next = 1'b1;
                    else if (w_long)   begin w_latch_hw = 1'b1; w_state_next = S_SECOND; end
                    else if (w_hazard) begin w_latch_hw = 1'b1; w_state_next = S_STALL; end
                    else               w_issue = 1'b1;
                end
                S_SECOND: if (w_accept) begin
                    if (w_hazard) begin w_latch_imm = 1'b1; w_state_next = S_STALL; end
                    else          begin w_issue = 1'b1; w_state_next = S_FIRST; end
                end
                S_STALL: begin
                    w_issue      = 1'b1;
                    w_state_next = S_FIRST;
                end
                default: w_state_next = S_FIRST;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hw      <= 16'h0000;
            r_imm     <= 16'h0000;
            r_dest    <= 5'd0;
            r_reg1    <= 32'd0;
            r_reg2    <= 32'd0;
            r_sel     <= NOP_SEL;
            r_illegal <= 1'b0;
            r_issued  <= 1'b0;
        end else begin
            r_illegal <= w_illegal_next;
            r_issued  <= w_issue;
            if (w_latch_hw)  r_hw  <= hw_i;
            if (w_latch_imm) r_imm <= hw_i;
            if (w_issue) begin
                r_sel  <= w_sel;
                r_dest <= w_dest;
                r_reg1 <= w_op1;
                r_reg2 <= w_op2;
            end else begin
                r_sel  <= NOP_SEL;
            end
        end
    end

    assign destination_o   = r_dest;
    assign reg1_o          = r_reg1;
    assign reg2_o          = r_reg2;
    assign reg3_o          = 32'd0;
    assign increment_bit_o = 1'b0;
    assign circuit_sel_o   = r_sel;
    assign illegal_o       = r_illegal;
endmodule
